full_adder_4bit: RTL and testbench
==================================

// Module: full_adder_4bit
//
// PURPOSE
//   Registered 4-bit ripple-carry adder: proC:sum = add + aug + preC.
//   Operands and carry-in are combinationally summed through a chain of
//   1-bit full-adder cells; the result is captured in output registers.
//   Arithmetic leaf block, cascadable via preC/proC for wider adders.
//
// PARAMETERS
//   WIDTH  4  operand/sum width in bits; the 4-bit configuration is the
//             one verified and must be fully supported
//
// PORTS
//   clk    input   1      single clock; all state updates on rising edge
//   rst_n  input   1      reset, asynchronous, active-low
//   proC   output  1      registered carry-out of the MSB cell
//   sum    output  WIDTH  registered sum bits
//   add    input   WIDTH  addend, unsigned
//   aug    input   WIDTH  augend, unsigned
//   preC   input   1      carry-in to the LSB cell
//
// BEHAVIOUR
//   - One clock clk; reset is asynchronous and active-low (rst_n).
//   - Reset: rst_n=0 immediately forces sum=0 and proC=0, independent of clk.
//     Outputs hold 0 while rst_n=0.
//   - Reset release: first rising clk edge with rst_n=1 loads a result.
//   - Datapath, purely combinational, per cell i = 0..WIDTH-1:
//       c[0]   = preC
//       s[i]   = add[i] ^ aug[i] ^ c[i]
//       c[i+1] = (add[i] & aug[i]) | (c[i] & (add[i] ^ aug[i]))
//   - Build the chain from explicit full-adder cell instances (generate loop).
//     The carry chain must not be a single '+' operator.
//   - Registers: at each rising clk edge with rst_n=1, sum <= s and
//     proC <= c[WIDTH].
//   - Latency: inputs stable before edge N appear on sum/proC after edge N.
//     Latency is 1 cycle, with one new result accepted every cycle.
//   - Width rule: {proC,sum} = add + aug + preC exactly, range 0..2^(WIDTH+1)-1.
//     No overflow is lost, and operands are unsigned.
//   - Boundary: all-ones operands with preC=1 give sum=all-ones, proC=1.
//     Carry propagates through every cell within one cycle.
//   - Inputs changing between edges have no effect until the next edge.
//     There are no glitches on the outputs.
//   - Reset mid-operation: the pending result is discarded and outputs go to 0.
//     Normal operation resumes on the first edge after release.
//   - X on any input may produce X on outputs; there is no X-masking.
//
// TESTING
//   1. add=0000, aug=0000, preC=0, one edge -> sum=0000, proC=0.
//   2. add=0000, aug=0000, preC=1 -> sum=0001, proC=0 after the next edge.
//   3. add=0101, aug=1010, preC=1 -> sum=0000, proC=1 (full carry ripple).
//   4. add=1111, aug=1111, preC=1 -> sum=1111, proC=1.
//      Then add=0101, aug=1010, preC=0 -> sum=1111, proC=0.
//   5. Load add=1111, aug=0001, preC=0 (sum=0000, proC=1).
//      Assert rst_n=0 between edges -> outputs 0 at once, without a clk edge.
//      Release -> next edge reloads the result.
//   6. Exhaustive sweep: all 512 (add,aug,preC) combinations, one per cycle.
//      Compare {proC,sum} with add+aug+preC one cycle later.

Source files
------------

// File: rtl/full_adder_4bit.sv
// full_adder_4bit
//   Registered ripple-carry adder: {proC,sum} = add + aug + preC.
//   A chain of full-adder cells forms the combinational sum. The result is
//   captured in output registers, so latency is one cycle and a new result
//   is accepted every cycle. preC and proC let several blocks be cascaded
//   into a wider adder.
//
//   Ports
//     clk    in   1      rising-edge clock
//     rst_n  in   1      asynchronous active-low reset; clears sum and proC
//     proC   out  1      registered carry-out of the MSB cell
//     sum    out  WIDTH  registered sum
//     add    in   WIDTH  addend, unsigned
//     aug    in   WIDTH  augend, unsigned
//     preC   in   1      carry-in to the LSB cell

// One bit of the adder. The carry uses the generate/propagate form, so the
// propagate term p is shared between the sum and the carry.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;
  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);
endmodule

module full_adder_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             proC,
  output logic [WIDTH-1:0] sum,
  input  logic [WIDTH-1:0] add,
  input  logic [WIDTH-1:0] aug,
  input  logic             preC
);

  // c[i] is the carry into cell i. c[WIDTH] is the carry out of the block.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = preC;

  // The carry ripples explicitly through one cell per bit.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    fa_cell u_fa (
      .a  (add[gi]),
      .b  (aug[gi]),
      .ci (c[gi]),
      .s  (s[gi]),
      .co (c[gi+1])
    );
  end

  // The outputs come only from registers, so ripple glitches in the chain
  // never reach sum or proC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      proC <= 1'b0;
    end else begin
      sum  <= s;
      proC <= c[WIDTH];
    end
  end

endmodule

// File: tb/tb_full_adder_4bit.sv
module tb_full_adder_4bit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       proC;
  logic [3:0] sum;
  logic [3:0] add;
  logic [3:0] aug;
  logic       preC;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  full_adder_4bit #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .proC  (proC),
    .sum   (sum),
    .add   (add),
    .aug   (aug),
    .preC  (preC)
  );

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got {proC,sum}=%b_%b want %b_%b", tag, obs[4], obs[3:0], exp[4], exp[3:0]);
    end
  endtask

  // Drive one vector, take one edge, then check the registered result 1 ns
  // after the edge.
  task automatic apply(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic ci, input logic [4:0] exp);
    add = a; aug = b; preC = ci;
    @(posedge clk); #1;
    chk(tag, {proC, sum}, exp);
  endtask

  initial begin
    rst_n = 1'b0; add = 4'hF; aug = 4'hF; preC = 1'b1;
    #1;
    chk("reset_async", {proC, sum}, 5'b0_0000);
    @(posedge clk); #1;
    chk("reset_hold_edge", {proC, sum}, 5'b0_0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors.
    apply("t1_zero",       4'b0000, 4'b0000, 1'b0, 5'b0_0000);
    apply("t2_cin_only",   4'b0000, 4'b0000, 1'b1, 5'b0_0001);
    apply("t3_full_rip",   4'b0101, 4'b1010, 1'b1, 5'b1_0000);
    apply("t4_all_ones",   4'b1111, 4'b1111, 1'b1, 5'b1_1111);
    apply("t4_alt_nocin",  4'b0101, 4'b1010, 1'b0, 5'b0_1111);
    apply("mix_3p6",       4'b0011, 4'b0110, 1'b0, 5'b0_1001);
    apply("mix_9p9c",      4'b1001, 4'b1001, 1'b1, 5'b1_0011);

    // Changing the inputs between edges must leave the outputs alone.
    add = 4'b0000; aug = 4'b0001; preC = 1'b0;
    #2;
    chk("between_edges", {proC, sum}, 5'b1_0011);

    // Reset in the middle of a cycle clears the outputs without a clock edge.
    apply("t5_load",       4'b1111, 4'b0001, 1'b0, 5'b1_0000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_reset_async", {proC, sum}, 5'b0_0000);
    @(posedge clk); #1;
    chk("t5_reset_edge", {proC, sum}, 5'b0_0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t5_reload", {proC, sum}, 5'b1_0000);

    // Exhaustive sweep, one vector per cycle.
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      logic [4:0] e;
      v = i[8:0];
      e = {1'b0, v[3:0]} + {1'b0, v[7:4]} + {4'b0, v[8]};
      apply("sweep", v[3:0], v[7:4], v[8], e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, got still running want done");
    $fatal(1);
  end

endmodule
